dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// One access per three cycles: accept, memory access, response strobe.
module dmem_arbiter #(
    parameter int X_LEN = 32,
    parameter int DEPTH = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             p0_valid_i,
    input  logic             p0_we_i,
    input  logic [X_LEN-1:0] p0_addr_i,
    input  logic [X_LEN-1:0] p0_wdata_i,
    output logic             p0_ready_o,
    output logic             p0_rsp_valid_o,
    output logic [X_LEN-1:0] p0_rsp_rdata_o,
    output logic             p0_rsp_err_o,
    input  logic             p1_valid_i,
    input  logic             p1_we_i,
    input  logic [X_LEN-1:0] p1_addr_i,
    input  logic [X_LEN-1:0] p1_wdata_i,
    output logic             p1_ready_o,
    output logic             p1_rsp_valid_o,
    output logic [X_LEN-1:0] p1_rsp_rdata_o,
    output logic             p1_rsp_err_o,
    output logic             mem_we_o,
    output logic [X_LEN-1:0] mem_addr_o,
    output logic [X_LEN-1:0] mem_wdata_o,
    input  logic [X_LEN-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    localparam logic [X_LEN-1:0] DEPTH_W = X_LEN'(DEPTH);

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic             we_q, we_d;
    logic             id_q, id_d;
    logic             err_q, err_d;
    logic [X_LEN-1:0] addr_q, addr_d;
    logic [X_LEN-1:0] wdata_q, wdata_d;
    logic [X_LEN-1:0] rdata_q, rdata_d;

    logic             any_valid;
    logic             win;
    logic [X_LEN-1:0] sel_addr;

    function automatic logic addr_err(input logic [X_LEN-1:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[X_LEN-1:2]} >= DEPTH_W);
    endfunction

    // Preferred port wins a tie; a lone requester always wins.
    assign any_valid = p0_valid_i | p1_valid_i;
    assign win       = (p0_valid_i && p1_valid_i) ? rr_q : p1_valid_i;
    assign sel_addr  = win ? p1_addr_i : p0_addr_i;

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        we_d           = we_q;
        id_d           = id_q;
        err_d          = err_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        p0_ready_o     = 1'b0;
        p1_ready_o     = 1'b0;
        p0_rsp_valid_o = 1'b0;
        p1_rsp_valid_o = 1'b0;
        p0_rsp_rdata_o = '0;
        p1_rsp_rdata_o = '0;
        p0_rsp_err_o   = 1'b0;
        p1_rsp_err_o   = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        unique case (state_q)
            IDLE: begin
                if (any_valid && !rst_i) begin
                    p0_ready_o = ~win;
                    p1_ready_o = win;
                    id_d       = win;
                    we_d       = win ? p1_we_i : p0_we_i;
                    addr_d     = sel_addr;
                    wdata_d    = win ? p1_wdata_i : p0_wdata_i;
                    err_d      = addr_err(sel_addr);
                    rr_d       = ~win;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                mem_we_o    = we_q & ~err_q;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                rdata_d     = (we_q || err_q) ? '0 : mem_rdata_i;
                state_d     = RESP;
            end
            RESP: begin
                p0_rsp_valid_o = ~id_q;
                p1_rsp_valid_o = id_q;
                p0_rsp_rdata_o = id_q ? '0 : rdata_q;
                p1_rsp_rdata_o = id_q ? rdata_q : '0;
                p0_rsp_err_o   = ~id_q & err_q;
                p1_rsp_err_o   = id_q & err_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            we_q    <= 1'b0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            we_q    <= we_d;
            id_q    <= id_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
